mult_mem_responder: RTL and testbench
=====================================

// Module: mult_mem_responder
// PURPOSE
//  Memory-side responder for the approximate multiplier's read/write strobes.
//  - Holds a table of 16-bit operand pairs that the host preloads.
//  - Answers each read strobe with the next pair.
//  - Stores each product returned on a write strobe into a result table.
//  - Raises all_done once NUM_OPS products have been written back.
//  - Sits between the testbench/host and the multiplier's datapath.
// PARAMETERS
//  DW       16  operand width in bits; products are 2*DW bits
//  DEPTH    16  operand-pair and result table entries (power of 2)
//  AW        4  address width, log2(DEPTH)
// PORTS
//  clk          in   1     rising-edge clock
//  rst          in   1     synchronous, active-high reset
//  host_we      in   1     host write to operand table this cycle
//  host_addr    in   AW    host operand/result table address
//  host_a       in   DW    operand A to store at host_addr
//  host_b       in   DW    operand B to store at host_addr
//  num_ops      in   AW+1  pairs to process, 1..DEPTH; sampled on arm
//  arm          in   1     pulse: clear pointers, latch num_ops, enter RUN
//  read         in   1     multiplier read strobe, 1-cycle pulse
//  write        in   1     multiplier write strobe, 1-cycle pulse
//  wdata        in   2*DW  product from multiplier, valid with write
//  op_a         out  DW    registered operand A
//  op_b         out  DW    registered operand B
//  rd_valid     out  1     1-cycle pulse: op_a/op_b updated
//  wr_ack       out  1     1-cycle pulse: wdata committed
//  all_done     out  1     level: num_ops results written
//  err          out  1     sticky: strobe out of range or outside RUN
//  res_data     out  2*DW  combinational result table read at host_addr
// BEHAVIOUR
//  Reset values
//  - All outputs 0; FSM in IDLE; rd_ptr and wr_ptr 0.
//  - Table contents are NOT cleared by rst.
//  FSM states
//  - IDLE: arm moves to RUN, clears both pointers and err, latches num_ops as n.
//  - RUN: services strobes. Goes to DONE in the cycle after wr_ptr reaches n.
//  - DONE: all_done=1. arm returns to RUN with the same arm actions.
//  - arm in RUN re-arms: same actions, and all_done drops.
//  Read (RUN, read=1, rd_ptr<n)
//  - Next cycle: op_a/op_b = table[rd_ptr], rd_valid=1.
//  - rd_ptr increments. Latency is exactly 1 cycle.
//  Write (RUN, write=1, wr_ptr<n)
//  - result[wr_ptr] <= wdata; wr_ack=1 next cycle; wr_ptr increments.
//  Simultaneous events
//  - read and write in the same cycle are both serviced, independently.
//  - host_we has no effect on a read in the same cycle to the same address;
//    the read returns the old pair.
//  Boundary and error cases
//  - read with rd_ptr==n, write with wr_ptr==n, or either strobe outside RUN:
//    ignored, no pulse, err<=1. err stays set until arm or rst.
//  - Outputs op_a/op_b hold their last value between reads.
//  - num_ops=0 on arm is treated as DEPTH.
//  - Pointers are AW+1 bits, so there is no wrap-around.
//  - rst mid-RUN: returns to IDLE, pointers 0, tables keep their contents.
//  - host_we is accepted in any state.
// TESTING
//  1. Preload A=3,B=5 @0 and A=0xFFFF,B=0xFFFF @1; arm, num_ops=2; read ->
//     next cycle op_a=3, op_b=5, rd_valid=1; second read -> 0xFFFF, 0xFFFF.
//  2. write wdata=15 then write wdata=0xFFFE0001 -> wr_ack each;
//     res_data@0=15, @1=0xFFFE0001; all_done=1 the cycle after the 2nd ack.
//  3. read and write in the same cycle mid-run -> rd_valid and wr_ack both
//     pulse next cycle; both pointers advance by 1.
//  4. Third read after num_ops=2 is exhausted -> no rd_valid, err=1,
//     op_a/op_b unchanged; arm -> err=0.
//  5. rst asserted mid-RUN after 1 write -> outputs 0, IDLE.
//     Re-arm and read -> op_a=3 (preload retained).
//  6. read with no prior arm -> err=1, no rd_valid.
//     arm with num_ops=0 -> 16 reads are accepted without err.

Source files
------------

// File: rtl/mult_mem_responder.sv
// Memory-side responder for the approximate multiplier: serves preloaded operand
// pairs on read strobes, captures products on write strobes, flags completion.
module mult_mem_responder #(
  parameter int DW    = 16,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            host_we,
  input  logic [AW-1:0]   host_addr,
  input  logic [DW-1:0]   host_a,
  input  logic [DW-1:0]   host_b,
  input  logic [AW:0]     num_ops,
  input  logic            arm,
  input  logic            read,
  input  logic            write,
  input  logic [2*DW-1:0] wdata,
  output logic [DW-1:0]   op_a,
  output logic [DW-1:0]   op_b,
  output logic            rd_valid,
  output logic            wr_ack,
  output logic            all_done,
  output logic            err,
  output logic [2*DW-1:0] res_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_e          state_q, state_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     n_q, n_d;
  logic [DW-1:0]   op_a_q, op_a_d;
  logic [DW-1:0]   op_b_q, op_b_d;
  logic            rd_valid_q, rd_valid_d;
  logic            wr_ack_q, wr_ack_d;
  logic            all_done_q, all_done_d;
  logic            err_q, err_d;

  logic [DW-1:0]   mem_a   [DEPTH];
  logic [DW-1:0]   mem_b   [DEPTH];
  logic [2*DW-1:0] mem_res [DEPTH];

  logic            rd_ok;
  logic            wr_ok;

  // arm takes priority over strobes in the same cycle; those strobes are dropped.
  assign rd_ok = (state_q == S_RUN) && read  && !arm && (rd_ptr_q < n_q);
  assign wr_ok = (state_q == S_RUN) && write && !arm && (wr_ptr_q < n_q);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (otherwise a latch is inferred).
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    n_d        = n_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    rd_valid_d = 1'b0;
    wr_ack_d   = 1'b0;
    all_done_d = all_done_q;
    err_d      = err_q;

    if (arm) begin
      state_d    = S_RUN;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      err_d      = 1'b0;
      all_done_d = 1'b0;
      // Zero (and anything beyond the table) means a full pass over the table.
      if (num_ops == '0 || num_ops > DEPTH_W) n_d = DEPTH_W;
      else                                     n_d = num_ops;
    end else begin
      if (read && !rd_ok)   err_d = 1'b1;
      if (write && !wr_ok)  err_d = 1'b1;

      if (rd_ok) begin
        op_a_d     = mem_a[rd_ptr_q[AW-1:0]];
        op_b_d     = mem_b[rd_ptr_q[AW-1:0]];
        rd_valid_d = 1'b1;
        rd_ptr_d   = rd_ptr_q + 1'b1;
      end

      if (wr_ok) begin
        wr_ack_d = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end

      if (state_q == S_RUN && wr_ptr_q == n_q) begin
        state_d    = S_DONE;
        all_done_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      n_q        <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      rd_valid_q <= 1'b0;
      wr_ack_q   <= 1'b0;
      all_done_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      n_q        <= n_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      rd_valid_q <= rd_valid_d;
      wr_ack_q   <= wr_ack_d;
      all_done_q <= all_done_d;
      err_q      <= err_d;
    end
  end

  // NOTE: the tables have no reset so they map onto plain RAM and survive rst.
  always_ff @(posedge clk) begin
    if (host_we) begin
      mem_a[host_addr] <= host_a;
      mem_b[host_addr] <= host_b;
    end
    if (wr_ok && !rst) begin
      mem_res[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

  assign op_a     = op_a_q;
  assign op_b     = op_b_q;
  assign rd_valid = rd_valid_q;
  assign wr_ack   = wr_ack_q;
  assign all_done = all_done_q;
  assign err      = err_q;
  assign res_data = mem_res[host_addr];

endmodule

// File: tb/tb_mult_mem_responder.sv
// Self-checking bench for mult_mem_responder: directed vector table, hand-written
// reset/boundary sequences, then randomized traffic against a behavioural model.
module tb_mult_mem_responder;
  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic            clk;
  logic            rst;
  logic            host_we;
  logic [AW-1:0]   host_addr;
  logic [DW-1:0]   host_a;
  logic [DW-1:0]   host_b;
  logic [AW:0]     num_ops;
  logic            arm;
  logic            read;
  logic            write;
  logic [2*DW-1:0] wdata;
  logic [DW-1:0]   op_a;
  logic [DW-1:0]   op_b;
  logic            rd_valid;
  logic            wr_ack;
  logic            all_done;
  logic            err;
  logic [2*DW-1:0] res_data;

  mult_mem_responder #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .host_we(host_we), .host_addr(host_addr),
    .host_a(host_a), .host_b(host_b), .num_ops(num_ops), .arm(arm),
    .read(read), .write(write), .wdata(wdata), .op_a(op_a), .op_b(op_b),
    .rd_valid(rd_valid), .wr_ack(wr_ack), .all_done(all_done), .err(err),
    .res_data(res_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: counts of reads/writes served in the current run.
  logic [DW-1:0]   m_a   [DEPTH];
  logic [DW-1:0]   m_b   [DEPTH];
  logic [2*DW-1:0] m_res [DEPTH];
  bit              m_known [DEPTH];
  bit              m_active, m_done, m_err, m_rv, m_ack;
  int              m_rc, m_wc, m_n;
  logic [DW-1:0]   m_opa, m_opb;

  task automatic model_step();
    bit running;
    bit finishing;
    m_rv  = 0;
    m_ack = 0;
    if (rst) begin
      m_active = 0; m_done = 0; m_err = 0;
      m_rc = 0; m_wc = 0; m_n = 0;
      m_opa = '0; m_opb = '0;
    end else if (arm) begin
      m_active = 1; m_done = 0; m_err = 0;
      m_rc = 0; m_wc = 0;
      m_n = (num_ops == 0 || int'(num_ops) > DEPTH) ? DEPTH : int'(num_ops);
    end else begin
      running   = m_active && !m_done;
      finishing = running && (m_wc == m_n);
      if (read) begin
        if (running && m_rc < m_n) begin
          m_opa = m_a[m_rc]; m_opb = m_b[m_rc]; m_rv = 1; m_rc++;
        end else m_err = 1;
      end
      if (write) begin
        if (running && m_wc < m_n) begin
          m_res[m_wc] = wdata; m_known[m_wc] = 1; m_ack = 1; m_wc++;
        end else m_err = 1;
      end
      if (finishing) m_done = 1;
    end
    if (host_we) begin
      m_a[host_addr] = host_a;
      m_b[host_addr] = host_b;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic idle_inputs();
    host_we = 0; arm = 0; read = 0; write = 0; wdata = '0; num_ops = '0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_op_a"}, op_a, 0);
    check({tag, "_op_b"}, op_b, 0);
    check({tag, "_rd_valid"}, rd_valid, 0);
    check({tag, "_wr_ack"}, wr_ack, 0);
    check({tag, "_all_done"}, all_done, 0);
    check({tag, "_err"}, err, 0);
  endtask

  typedef struct {
    bit              arm;
    logic [AW:0]     num_ops;
    bit              rd;
    bit              wr;
    logic [2*DW-1:0] wdata;
    bit              rv;
    bit              ack;
    bit              done;
    bit              err;
    logic [DW-1:0]   a;
    logic [DW-1:0]   b;
  } vec_t;

  vec_t vecs[11];

  initial begin
    //           arm n  rd wr wdata          rv ack dn er a         b
    vecs[0]  = '{1, 5'd2, 0, 0, 32'h0,        0, 0, 0, 0, 16'h0,    16'h0};
    vecs[1]  = '{0, 5'd0, 1, 0, 32'h0,        1, 0, 0, 0, 16'h3,    16'h5};
    vecs[2]  = '{0, 5'd0, 0, 1, 32'd15,       0, 1, 0, 0, 16'h3,    16'h5};
    vecs[3]  = '{0, 5'd0, 1, 1, 32'hFFFE0001, 1, 1, 0, 0, 16'hFFFF, 16'hFFFF};
    vecs[4]  = '{0, 5'd0, 0, 0, 32'h0,        0, 0, 1, 0, 16'hFFFF, 16'hFFFF};
    vecs[5]  = '{0, 5'd0, 1, 0, 32'h0,        0, 0, 1, 1, 16'hFFFF, 16'hFFFF};
    vecs[6]  = '{1, 5'd2, 0, 0, 32'h0,        0, 0, 0, 0, 16'hFFFF, 16'hFFFF};
    vecs[7]  = '{0, 5'd0, 1, 0, 32'h0,        1, 0, 0, 0, 16'h3,    16'h5};
    vecs[8]  = '{0, 5'd0, 1, 0, 32'h0,        1, 0, 0, 0, 16'hFFFF, 16'hFFFF};
    vecs[9]  = '{0, 5'd0, 1, 0, 32'h0,        0, 0, 0, 1, 16'hFFFF, 16'hFFFF};
    vecs[10] = '{1, 5'd2, 0, 0, 32'h0,        0, 0, 0, 0, 16'hFFFF, 16'hFFFF};

    rst = 1; host_addr = '0; host_a = '0; host_b = '0;
    idle_inputs();
    cycle(); cycle();
    check_outputs_zero("reset");
    rst = 0;

    // Preload the two pairs used by the directed vectors.
    host_we = 1; host_addr = 0; host_a = 16'd3;    host_b = 16'd5;    cycle();
    host_we = 1; host_addr = 1; host_a = 16'hFFFF; host_b = 16'hFFFF; cycle();
    host_we = 0;

    for (int i = 0; i < 11; i++) begin
      arm = vecs[i].arm; num_ops = vecs[i].num_ops;
      read = vecs[i].rd; write = vecs[i].wr; wdata = vecs[i].wdata;
      cycle();
      check($sformatf("vec%0d_rd_valid", i), rd_valid, vecs[i].rv);
      check($sformatf("vec%0d_wr_ack", i),   wr_ack,   vecs[i].ack);
      check($sformatf("vec%0d_all_done", i), all_done, vecs[i].done);
      check($sformatf("vec%0d_err", i),      err,      vecs[i].err);
      check($sformatf("vec%0d_op_a", i),     op_a,     vecs[i].a);
      check($sformatf("vec%0d_op_b", i),     op_b,     vecs[i].b);
    end
    idle_inputs();

    host_addr = 0; #1; check("res_data_0", res_data, 32'd15);
    host_addr = 1; #1; check("res_data_1", res_data, 32'hFFFE0001);

    // Reset mid-run after one write; operand table must survive.
    write = 1; wdata = 32'd7; cycle(); write = 0;
    check("midrun_wr_ack", wr_ack, 1);
    rst = 1; cycle(); rst = 0;
    check_outputs_zero("midrun_rst");
    arm = 1; num_ops = 5'd2; cycle(); arm = 0;
    read = 1; cycle(); read = 0;
    check("rearm_rd_valid", rd_valid, 1);
    check("rearm_op_a", op_a, 16'd3);
    check("rearm_op_b", op_b, 16'd5);

    // Read without arm, then a full num_ops=0 pass over a freshly loaded table.
    rst = 1; cycle(); rst = 0;
    read = 1; cycle(); read = 0;
    check("noarm_err", err, 1);
    check("noarm_rd_valid", rd_valid, 0);
    for (int i = 0; i < DEPTH; i++) begin
      host_we = 1; host_addr = AW'(i);
      host_a = 16'(i * 16'h111 + 1); host_b = 16'(16'hA000 + i);
      cycle();
    end
    host_we = 0;
    arm = 1; num_ops = 5'd0; cycle(); arm = 0;
    check("zero_arm_err", err, 0);
    for (int i = 0; i < DEPTH; i++) begin
      read = 1; cycle();
      check($sformatf("full_rd%0d_valid", i), rd_valid, 1);
      check($sformatf("full_rd%0d_err", i), err, 0);
      check($sformatf("full_rd%0d_op_a", i), op_a, 16'(i * 16'h111 + 1));
      check($sformatf("full_rd%0d_op_b", i), op_b, 16'(16'hA000 + i));
    end
    cycle(); read = 0;
    check("full_extra_rd_valid", rd_valid, 0);
    check("full_extra_err", err, 1);

    // Randomized traffic against the model.
    rst = 1; cycle(); rst = 0;
    for (int i = 0; i < DEPTH; i++) m_known[i] = 0;
    for (int c = 0; c < 1500; c++) begin
      arm       = ($urandom % 40) == 0;
      num_ops   = 5'($urandom % 17);
      read      = $urandom % 2;
      write     = $urandom % 2;
      wdata     = $urandom;
      host_we   = ($urandom % 4) == 0;
      host_addr = AW'($urandom);
      host_a    = DW'($urandom);
      host_b    = DW'($urandom);
      cycle();
      check("rnd_rd_valid", rd_valid, m_rv);
      check("rnd_wr_ack",   wr_ack,   m_ack);
      check("rnd_all_done", all_done, m_done);
      check("rnd_err",      err,      m_err);
      check("rnd_op_a",     op_a,     m_opa);
      check("rnd_op_b",     op_b,     m_opb);
      if (m_known[host_addr]) check("rnd_res_data", res_data, m_res[host_addr]);
    end
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
